id_ex_stage_reg: RTL
====================

// Module: id_ex_stage_reg
// PURPOSE
//   ID/EX pipeline register of the 5-stage MIPS core. It sits directly downstream of the
//   Decoder and captures the control word, register-file read data, the sign-extended
//   immediate and the register indices for the EX stage.
//   It also performs load-use hazard detection, inserts bubbles, honours branch flushes,
//   and keeps saturating stall and flush event counters.
// PARAMETERS
//   DATA_W      32  width of datapath words (rs/rt data, immediate, pc+4)
//   REG_AW       5  register index width
//   CNT_W       16  width of the stall and flush event counters
// PORTS
//   clk_i         in   1       clock; all state updates on rising edge
//   rst_i         in   1       synchronous reset, active-low
//   id_valid_i    in   1       ID slot holds a real instruction
//   id_ctrl_i     in   10      {RegWrite,ALU_op[2:0],ALUSrc,RegDst,Branch,MEM_Write,MEM_Read,MEM2Reg}
//   id_pc4_i      in   DATA_W  pc+4 of the ID instruction
//   id_rs_data_i  in   DATA_W  register-file read port 1
//   id_rt_data_i  in   DATA_W  register-file read port 2
//   id_imm_i      in   DATA_W  sign-extended immediate
//   id_rs_i       in   REG_AW  rs index; id_rt_i / id_rd_i: same width, rt / rd indices
//   flush_i       in   1       branch taken (from MEM); kill the ID instruction
//   stall_o       out  1       combinational; hold PC and IF/ID this cycle
//   ex_valid_o    out  1       EX slot valid
//   ex_ctrl_o     out  10      registered control word, same packing as id_ctrl_i
//   ex_pc4_o, ex_rs_data_o, ex_rt_data_o, ex_imm_o   out  DATA_W  registered copies
//   ex_rs_o, ex_rt_o, ex_rd_o                        out  REG_AW  registered copies
//   stall_cnt_o   out  CNT_W   number of bubble cycles caused by load-use stalls
//   flush_cnt_o   out  CNT_W   number of flushed valid ID instructions
// BEHAVIOUR
//   Reset (rst_i==0 at a rising edge): all ex_* outputs and both counters go to 0.
//     This takes priority over every other event, including a reset mid-stall or mid-flush.
//   Hazard: hz = id_valid_i & ex_valid_o & ex_ctrl_o.MEM_Read & (ex_rt_o != 0)
//     & ((ex_rt_o == id_rs_i) | (ex_rt_o == id_rt_i)).
//     The rt comparison is conservative and applies to every opcode.
//   stall_o = hz & ~flush_i. It is purely combinational and never registered.
//   Next-state priority at each rising edge:
//     1. reset.
//     2. flush_i: load a bubble (ex_valid_o=0, ex_ctrl_o=0, data and indices=0).
//        flush_cnt_o increments when id_valid_i=1.
//     3. stall_o: load a bubble; stall_cnt_o increments.
//     4. otherwise: load all id_* inputs. ex_valid_o=id_valid_i.
//        If id_valid_i==0, ex_ctrl_o is forced to 0.
//   Latency: exactly 1 cycle from ID inputs to ex_* outputs. There is no internal buffering.
//   A stall lasts exactly 1 cycle per load-use pair. After the bubble, ex_valid_o=0, so hz=0.
//   Flush and hazard in the same cycle: flush wins, stall_o=0, only flush_cnt_o increments.
//   Counters saturate at all-ones and do not wrap. Only reset clears them.
//   A bubble must carry RegWrite=MEM_Write=MEM_Read=Branch=0, so it has no architectural effect.
// STRUCTURE
//   cpu_pkg holds:
//     CTRL_W=10, the control-field bit offsets, CTRL_BUBBLE=10'b0,
//     and the ALU_op encodings shared with Decoder and ALU_Ctrl.
//   One sub-module, load_use_detect: a combinational hz compare. It is reused by the
//     forwarding unit tests.
//   The rest is one clocked always block for the pipeline register and counters.
// TESTING
//   1. Reset: rst_i=0 for 2 cycles with random inputs.
//      -> all ex_* = 0, counters = 0, stall_o = 0.
//   2. Pass-through: valid add with rs=3, rt=4, rd=5, ctrl=10'b1_010_0_1_0_0_0_0.
//      -> next cycle ex_* equal the inputs, ex_valid_o=1.
//   3. Load-use: lw $2 then add $4,$2,$3.
//      -> stall_o=1 for 1 cycle, then a bubble in EX. The add enters EX one cycle later.
//      -> stall_cnt_o=1.
//   4. No hazard on $0: lw $0 then add using $0. -> stall_o stays 0.
//      No hazard when ex is a store (MEM_Read=0).
//   5. Flush during hazard: lw $2, add $4,$2,$3 with flush_i=1.
//      -> stall_o=0, bubble loaded, flush_cnt_o=1, stall_cnt_o=0.
//   6. Saturation: force 2^CNT_W+3 stalls (use CNT_W=4).
//      -> stall_cnt_o holds 4'hF. Reset mid-stall clears it to 0 the next edge.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the 5-stage MIPS core: control-word layout,
// bubble encoding and the ALU operation codes used by Decoder and ALU_Ctrl.
package cpu_pkg;

  localparam int CTRL_W = 10;

  // Bit positions inside {RegWrite,ALU_op[2:0],ALUSrc,RegDst,Branch,MEM_Write,MEM_Read,MEM2Reg}
  localparam int CTRL_REGWRITE = 9;
  localparam int CTRL_ALUOP_HI = 8;
  localparam int CTRL_ALUOP_LO = 6;
  localparam int CTRL_ALUSRC   = 5;
  localparam int CTRL_REGDST   = 4;
  localparam int CTRL_BRANCH   = 3;
  localparam int CTRL_MEMWRITE = 2;
  localparam int CTRL_MEMREAD  = 1;
  localparam int CTRL_MEM2REG  = 0;

  localparam logic [CTRL_W-1:0] CTRL_BUBBLE = 10'b00_0000_0000;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_op_e;

  function automatic logic ctrl_mem_read(input logic [CTRL_W-1:0] ctrl);
    return ctrl[CTRL_MEMREAD];
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard compare between the load sitting in EX and the instruction in ID.
// Purely combinational; also reused by the forwarding unit tests.
module load_use_detect #(
  parameter int REG_AW = 5
) (
  input  logic              id_valid,
  input  logic              ex_valid,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  output logic              hz
);

  logic rt_nonzero_s;
  logic idx_match_s;

  // $0 is hard-wired, so a load into it can never create a dependency.
  // The rt compare is conservative: it fires even for opcodes that do not read rt.
  assign rt_nonzero_s = (ex_rt != {REG_AW{1'b0}});
  assign idx_match_s  = (ex_rt == id_rs) | (ex_rt == id_rt);
  assign hz           = id_valid & ex_valid & ex_mem_read & rt_nonzero_s & idx_match_s;

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register: captures decoded state for EX, inserts bubbles on
// load-use stalls and branch flushes, and keeps saturating stall/flush counters.
module id_ex_stage_reg
  import cpu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              id_valid_i,
  input  logic [CTRL_W-1:0] id_ctrl_i,
  input  logic [DATA_W-1:0] id_pc4_i,
  input  logic [DATA_W-1:0] id_rs_data_i,
  input  logic [DATA_W-1:0] id_rt_data_i,
  input  logic [DATA_W-1:0] id_imm_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic              flush_i,
  output logic              stall_o,
  output logic              ex_valid_o,
  output logic [CTRL_W-1:0] ex_ctrl_o,
  output logic [DATA_W-1:0] ex_pc4_o,
  output logic [DATA_W-1:0] ex_rs_data_o,
  output logic [DATA_W-1:0] ex_rt_data_o,
  output logic [DATA_W-1:0] ex_imm_o,
  output logic [REG_AW-1:0] ex_rs_o,
  output logic [REG_AW-1:0] ex_rt_o,
  output logic [REG_AW-1:0] ex_rd_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);

  localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};
  localparam logic [REG_AW-1:0] IDX_ZERO  = {REG_AW{1'b0}};

  logic              hz_s;
  logic              stall_s;
  logic              kill_s;
  logic              ex_valid_r;
  logic [CTRL_W-1:0] ex_ctrl_r;
  logic [DATA_W-1:0] ex_pc4_r;
  logic [DATA_W-1:0] ex_rs_data_r;
  logic [DATA_W-1:0] ex_rt_data_r;
  logic [DATA_W-1:0] ex_imm_r;
  logic [REG_AW-1:0] ex_rs_r;
  logic [REG_AW-1:0] ex_rt_r;
  logic [REG_AW-1:0] ex_rd_r;
  logic [CNT_W-1:0]  stall_cnt_r;
  logic [CNT_W-1:0]  flush_cnt_r;

  load_use_detect #(.REG_AW(REG_AW)) u_load_use_detect (
    .id_valid    (id_valid_i),
    .ex_valid    (ex_valid_r),
    .ex_mem_read (ctrl_mem_read(ex_ctrl_r)),
    .ex_rt       (ex_rt_r),
    .id_rs       (id_rs_i),
    .id_rt       (id_rt_i),
    .hz          (hz_s)
  );

  // A flush kills the dependent instruction anyway, so it suppresses the stall.
  assign stall_s = hz_s & ~flush_i;
  assign kill_s  = flush_i | stall_s;
  assign stall_o = stall_s;

  // Pipeline register plus saturating event counters; reset outranks flush and stall.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      ex_valid_r   <= 1'b0;
      ex_ctrl_r    <= CTRL_BUBBLE;
      ex_pc4_r     <= DATA_ZERO;
      ex_rs_data_r <= DATA_ZERO;
      ex_rt_data_r <= DATA_ZERO;
      ex_imm_r     <= DATA_ZERO;
      ex_rs_r      <= IDX_ZERO;
      ex_rt_r      <= IDX_ZERO;
      ex_rd_r      <= IDX_ZERO;
      stall_cnt_r  <= CNT_ZERO;
      flush_cnt_r  <= CNT_ZERO;
    end else begin
      if (kill_s) begin
        ex_valid_r   <= 1'b0;
        ex_ctrl_r    <= CTRL_BUBBLE;
        ex_pc4_r     <= DATA_ZERO;
        ex_rs_data_r <= DATA_ZERO;
        ex_rt_data_r <= DATA_ZERO;
        ex_imm_r     <= DATA_ZERO;
        ex_rs_r      <= IDX_ZERO;
        ex_rt_r      <= IDX_ZERO;
        ex_rd_r      <= IDX_ZERO;
      end else begin
        ex_valid_r   <= id_valid_i;
        ex_ctrl_r    <= id_valid_i ? id_ctrl_i : CTRL_BUBBLE;
        ex_pc4_r     <= id_pc4_i;
        ex_rs_data_r <= id_rs_data_i;
        ex_rt_data_r <= id_rt_data_i;
        ex_imm_r     <= id_imm_i;
        ex_rs_r      <= id_rs_i;
        ex_rt_r      <= id_rt_i;
        ex_rd_r      <= id_rd_i;
      end
      if (flush_i && id_valid_i && (flush_cnt_r != CNT_MAX)) begin
        flush_cnt_r <= flush_cnt_r + CNT_ONE;
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
      if (stall_s && (stall_cnt_r != CNT_MAX)) begin
        stall_cnt_r <= stall_cnt_r + CNT_ONE;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
    end
  end

  assign ex_valid_o   = ex_valid_r;
  assign ex_ctrl_o    = ex_ctrl_r;
  assign ex_pc4_o     = ex_pc4_r;
  assign ex_rs_data_o = ex_rs_data_r;
  assign ex_rt_data_o = ex_rt_data_r;
  assign ex_imm_o     = ex_imm_r;
  assign ex_rs_o      = ex_rs_r;
  assign ex_rt_o      = ex_rt_r;
  assign ex_rd_o      = ex_rd_r;
  assign stall_cnt_o  = stall_cnt_r;
  assign flush_cnt_o  = flush_cnt_r;

endmodule
